// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl
//   Left-to-right square-and-multiply sequencer for modular exponentiation.
//   Drives an external Montgomery multiplier core over a start/done
//   handshake and accumulates A = X^E in the Montgomery domain.
//   The operands X and R mod M arrive already converted.
//
//   Optional feature macro: MONT_EXP_FROMMONT_EN
//     When it is defined, one extra mont(A, 1) runs after the last exponent
//     bit, so the result leaves the block in normal form.
//     When it is undefined, the result stays in Montgomery form.
//
//   All outputs are registered. A multiplier start pulse is driven during
//   its GO state. done is raised in the cycle after FIN.
module mont_exp_ctrl #(
   parameter int WIDTH = 512,
   parameter int EBITS = 512,
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_r,
   input  logic [WIDTH-1:0] in_m,
   input  logic [EBITS-1:0] in_e,
   input  logic [CNT_W-1:0] in_elen,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic             mul_start,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   output logic [WIDTH-1:0] mul_m,
   input  logic [WIDTH-1:0] mul_result,
   input  logic             mul_done
);

   // state     | meaning
   // ----------+-------------------------------------------------------
   // IDLE      | waiting for start; done is raised here after FIN
   // SQR_GO    | mul_start pulse, operands A*A
   // SQR_WAIT  | waiting for the square result
   // MUL_GO    | mul_start pulse, operands A*X
   // MUL_WAIT  | waiting for the multiply result
   // NEXT      | exponent bit finished; loop or finish
   // CONV_GO   | mul_start pulse, operands A*1 (macro builds only)
   // CONV_WAIT | waiting for the conversion result (macro builds only)
   // FIN       | copy A to result; done follows in the next cycle
   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      SQR_GO    = 4'd1,
      SQR_WAIT  = 4'd2,
      MUL_GO    = 4'd3,
      MUL_WAIT  = 4'd4,
      NEXT      = 4'd5,
`ifdef MONT_EXP_FROMMONT_EN
      CONV_GO   = 4'd6,
      CONV_WAIT = 4'd7,
`endif
      FIN       = 4'd8
   } state_t;

`ifdef MONT_EXP_FROMMONT_EN
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
`endif

   state_t             state;
   state_t             state_n;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   a_next;
   logic [WIDTH-1:0]   x_q;
   logic [EBITS-1:0]   e_q;
   logic [CNT_W-1:0]   i_q;
   logic [CNT_W-1:0]   i_next;
   logic [CNT_W-1:0]   elen_cl;
   logic [CNT_W-1:0]   bit_idx;
   logic [EBITS-1:0]   e_mask;
   logic               e_bit;
   logic               accept;

   assign accept  = (state == IDLE) && start;
   assign elen_cl = (in_elen > CNT_W'(EBITS)) ? CNT_W'(EBITS) : in_elen;

   // The exponent bit under test is e[i-1].
   // A mask avoids a variable part-select on the wide exponent.
   assign bit_idx = i_q - 1'b1;
   assign e_mask  = {{(EBITS-1){1'b0}}, 1'b1} << bit_idx;
   assign e_bit   = |(e_q & e_mask);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state, next accumulator value and next bit index
   always_comb begin
      state_n = state;
      a_next  = acc;
      i_next  = i_q;
      case (state)
         IDLE: begin
            if (start) begin
               a_next = in_r;
               i_next = elen_cl;
               if (elen_cl == '0) begin
`ifdef MONT_EXP_FROMMONT_EN
                  state_n = CONV_GO;
`else
                  state_n = FIN;
`endif
               end else begin
                  state_n = SQR_GO;
               end
            end
         end
         SQR_GO: state_n = SQR_WAIT;
         SQR_WAIT: begin
            if (mul_done) begin
               a_next = mul_result;
               if (e_bit) begin
                  state_n = MUL_GO;
               end else begin
                  i_next  = i_q - 1'b1;
                  state_n = NEXT;
               end
            end
         end
         MUL_GO: state_n = MUL_WAIT;
         MUL_WAIT: begin
            if (mul_done) begin
               a_next  = mul_result;
               i_next  = i_q - 1'b1;
               state_n = NEXT;
            end
         end
         NEXT: begin
            if (i_q == '0) begin
`ifdef MONT_EXP_FROMMONT_EN
               state_n = CONV_GO;
`else
               state_n = FIN;
`endif
            end else begin
               state_n = SQR_GO;
            end
         end
`ifdef MONT_EXP_FROMMONT_EN
         CONV_GO: state_n = CONV_WAIT;
         CONV_WAIT: begin
            if (mul_done) begin
               a_next  = mul_result;
               state_n = FIN;
            end
         end
`endif
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath and registered outputs.
   // Operands are loaded on entry to a GO state and held until the next GO.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         x_q       <= '0;
         e_q       <= '0;
         i_q       <= '0;
         result    <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_m     <= '0;
      end else begin
         acc <= a_next;
         i_q <= i_next;
         if (accept) begin
            x_q   <= in_x;
            e_q   <= in_e;
            mul_m <= in_m;
         end
         mul_start <= 1'b0;
         if (state_n == SQR_GO) begin
            mul_start <= 1'b1;
            mul_a     <= a_next;
            mul_b     <= a_next;
         end
         if (state_n == MUL_GO) begin
            mul_start <= 1'b1;
            mul_a     <= a_next;
            mul_b     <= x_q;
         end
`ifdef MONT_EXP_FROMMONT_EN
         if (state_n == CONV_GO) begin
            mul_start <= 1'b1;
            mul_a     <= a_next;
            mul_b     <= ONE;
         end
`endif
         done <= (state == FIN);
         if (state == FIN) begin
            result <= acc;
         end
         // Busy stays high through the done cycle that follows FIN.
         busy <= (state_n != IDLE) || (state == FIN);
      end
   end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl.
// It uses an 8-bit instance and a 512-bit instance.
// Each instance drives a behavioural Montgomery core.
// The core returns a*b*R^-1 mod m exactly 5 cycles after each mul_start.
module tb_mont_exp_ctrl;

   localparam int L = 5;
`ifdef MONT_EXP_FROMMONT_EN
   localparam int CONV = 1;
`else
   localparam int CONV = 0;
`endif

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 8-bit instance
   logic       start8;
   logic [7:0] x8, r8, m8, e8;
   logic [3:0] elen8;
   logic [7:0] result8, ma8, mb8, mm8, mr8;
   logic       done8, busy8, ms8, md8, sdone8, inj8;

   assign md8 = sdone8 | inj8;

   mont_exp_ctrl #(.WIDTH(8), .EBITS(8), .CNT_W(4)) d8 (
      .clk(clk), .reset(reset), .start(start8),
      .in_x(x8), .in_r(r8), .in_m(m8), .in_e(e8), .in_elen(elen8),
      .result(result8), .done(done8), .busy(busy8),
      .mul_start(ms8), .mul_a(ma8), .mul_b(mb8), .mul_m(mm8),
      .mul_result(mr8), .mul_done(md8)
   );

   // 512-bit instance
   logic         start5;
   logic [511:0] x5, r5, m5, e5;
   logic [9:0]   elen5;
   logic [511:0] result5, ma5, mb5, mm5, mr5;
   logic         done5, busy5, ms5, md5;

   mont_exp_ctrl d512 (
      .clk(clk), .reset(reset), .start(start5),
      .in_x(x5), .in_r(r5), .in_m(m5), .in_e(e5), .in_elen(elen5),
      .result(result5), .done(done5), .busy(busy5),
      .mul_start(ms5), .mul_a(ma5), .mul_b(mb5), .mul_m(mm5),
      .mul_result(mr5), .mul_done(md5)
   );

   // Bit-serial Montgomery product with R = 2^w.
   // It requires a, b < m and an odd m.
   function automatic logic [513:0] mont_f(input logic [513:0] a, input logic [513:0] b,
                                           input logic [513:0] m, input int w);
      logic [513:0] t;
      t = '0;
      for (int k = 0; k < w; k++) begin
         if (a[k]) t = t + b;
         if (t[0]) t = t + m;
         t = t >> 1;
      end
      if (t >= m) t = t - m;
      return t;
   endfunction

   // Core stub for the 8-bit instance.
   // The product is taken from the operands present when done is raised,
   // so operand drift is caught in the result.
   logic [2:0]   scnt8;
   logic         spend8;
   logic [513:0] tmp8;
   always @(posedge clk) begin
      if (reset) begin
         spend8 <= 1'b0;
         sdone8 <= 1'b0;
         scnt8  <= '0;
         mr8    <= '0;
      end else begin
         sdone8 <= 1'b0;
         if (spend8) begin
            if (scnt8 == 3'd1) begin
               tmp8 = mont_f({506'd0, ma8}, {506'd0, mb8}, {506'd0, mm8}, 8);
               mr8    <= tmp8[7:0];
               sdone8 <= 1'b1;
               spend8 <= 1'b0;
            end else begin
               scnt8 <= scnt8 - 3'd1;
            end
         end
         if (ms8) begin
            spend8 <= 1'b1;
            scnt8  <= 3'(L - 1);
         end
      end
   end

   // Core stub for the 512-bit instance
   logic [2:0]   scnt5;
   logic         spend5;
   logic [513:0] tmp5;
   always @(posedge clk) begin
      if (reset) begin
         spend5 <= 1'b0;
         md5    <= 1'b0;
         scnt5  <= '0;
         mr5    <= '0;
      end else begin
         md5 <= 1'b0;
         if (spend5) begin
            if (scnt5 == 3'd1) begin
               tmp5 = mont_f({2'b00, ma5}, {2'b00, mb5}, {2'b00, mm5}, 512);
               mr5    <= tmp5[511:0];
               md5    <= 1'b1;
               spend5 <= 1'b0;
            end else begin
               scnt5 <= scnt5 - 3'd1;
            end
         end
         if (ms5) begin
            spend5 <= 1'b1;
            scnt5  <= 3'(L - 1);
         end
      end
   end

   // One 8-bit exponentiation.
   // cycles counts edges from the cycle start is raised to the first cycle with done high.
   // inject raises mul_done during the first SQR_GO.
   // restart raises start again while the block is busy.
   task automatic run8(input logic [7:0] x, input logic [7:0] r, input logic [7:0] m,
                       input logic [7:0] e, input logic [3:0] elen,
                       input bit inject, input bit restart,
                       output logic [7:0] res, output int cycles, output int pulses,
                       output int viol, output logic done_after,
                       output logic busy_at, output logic busy_after);
      logic [7:0] ca, cb;
      bit track, got;
      res = '0; cycles = 0; pulses = 0; viol = 0; track = 0; got = 0;
      ca = '0; cb = '0; busy_at = 1'b0; busy_after = 1'b1; done_after = 1'b1;
      @(negedge clk);
      x8 = x; r8 = r; m8 = m; e8 = e; elen8 = elen; start8 = 1'b1;
      while (!got && cycles < 300) begin
         @(posedge clk);
         #1;
         cycles++;
         inj8 = 1'b0;
         start8 = (restart && cycles == 3);
         if (track) begin
            if (ma8 !== ca || mb8 !== cb) viol++;
            if (md8) track = 0;
         end
         if (ms8) begin
            pulses++;
            ca = ma8; cb = mb8; track = 1;
            if (inject && pulses == 1) inj8 = 1'b1;
         end
         if (done8) begin
            got = 1; res = result8; busy_at = busy8;
         end
      end
      inj8 = 1'b0;
      start8 = 1'b0;
      @(posedge clk);
      #1;
      done_after = done8;
      busy_after = busy8;
   endtask

   task automatic run512(input logic [511:0] x, input logic [511:0] r, input logic [511:0] m,
                         input logic [511:0] e, input logic [9:0] elen,
                         output logic [511:0] res, output int cycles);
      bit got;
      got = 0; cycles = 0; res = '0;
      @(negedge clk);
      x5 = x; r5 = r; m5 = m; e5 = e; elen5 = elen; start5 = 1'b1;
      while (!got && cycles < 300) begin
         @(posedge clk);
         #1;
         cycles++;
         start5 = 1'b0;
         if (done5) begin
            got = 1; res = result5;
         end
      end
      start5 = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({result8, done8, busy8, ms8, ma8, mb8, mm8} !== 43'd0) begin
         n_fail++;
         $display("FAIL reset8: got result=%h done=%b busy=%b ms=%b a=%h b=%h m=%h, want all 0",
                  result8, done8, busy8, ms8, ma8, mb8, mm8);
      end
      n_tests++;
      if (result5 !== '0 || done5 !== 1'b0 || busy5 !== 1'b0 || ms5 !== 1'b0 ||
          ma5 !== '0 || mb5 !== '0 || mm5 !== '0) begin
         n_fail++;
         $display("FAIL reset512: got done=%b busy=%b ms=%b, want 0 with zero buses",
                  done5, busy5, ms5);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   // m=13, R mod m=9, X*R mod m=5, e=5, elen=3
   task automatic test_basic;
      logic [7:0] res, exp_res;
      int cyc, pul, viol;
      logic da, ba, bb;
      exp_res = (CONV != 0) ? 8'h06 : 8'h02;
      run8(8'd5, 8'd9, 8'd13, 8'd5, 4'd3, 1'b0, 1'b0, res, cyc, pul, viol, da, ba, bb);
      n_tests++;
      if (res !== exp_res) begin
         n_fail++; $display("FAIL basic_result: got %h want %h", res, exp_res);
      end
      n_tests++;
      if (pul !== 5 + CONV) begin
         n_fail++; $display("FAIL basic_pulses: got %0d want %0d", pul, 5 + CONV);
      end
      n_tests++;
      if (cyc !== 35 + 6 * CONV) begin
         n_fail++; $display("FAIL basic_cycles: got %0d want %0d", cyc, 35 + 6 * CONV);
      end
      n_tests++;
      if (ba !== 1'b1 || bb !== 1'b0) begin
         n_fail++; $display("FAIL basic_busy: at done %b after %b, want 1 then 0", ba, bb);
      end
      n_tests++;
      if (mm8 !== 8'd13) begin
         n_fail++; $display("FAIL basic_mul_m: got %h want 0d", mm8);
      end
   endtask

   task automatic test_elen_zero;
      logic [7:0] res, exp_res;
      int cyc, pul, viol;
      logic da, ba, bb;
      exp_res = (CONV != 0) ? 8'h01 : 8'h09;
      run8(8'd5, 8'd9, 8'd13, 8'hFF, 4'd0, 1'b0, 1'b0, res, cyc, pul, viol, da, ba, bb);
      n_tests++;
      if (res !== exp_res) begin
         n_fail++; $display("FAIL elen0_result: got %h want %h", res, exp_res);
      end
      n_tests++;
      if (cyc !== 2 + 6 * CONV) begin
         n_fail++; $display("FAIL elen0_cycles: got %0d want %0d", cyc, 2 + 6 * CONV);
      end
      n_tests++;
      if (pul !== CONV) begin
         n_fail++; $display("FAIL elen0_pulses: got %0d want %0d", pul, CONV);
      end
   endtask

   // e=1011: S,M,S,S,M,S,M. X=2 gives X^11 mod 13 = 7, and 7*9 mod 13 = 11.
   task automatic test_pattern_1011;
      logic [7:0] res, exp_res;
      int cyc, pul, viol;
      logic da, ba, bb;
      exp_res = (CONV != 0) ? 8'h07 : 8'h0B;
      run8(8'd5, 8'd9, 8'd13, 8'b1011, 4'd4, 1'b0, 1'b0, res, cyc, pul, viol, da, ba, bb);
      n_tests++;
      if (res !== exp_res) begin
         n_fail++; $display("FAIL p1011_result: got %h want %h", res, exp_res);
      end
      n_tests++;
      if (pul !== 7 + CONV) begin
         n_fail++; $display("FAIL p1011_pulses: got %0d want %0d", pul, 7 + CONV);
      end
      n_tests++;
      if (cyc !== 48 + 6 * CONV) begin
         n_fail++; $display("FAIL p1011_cycles: got %0d want %0d", cyc, 48 + 6 * CONV);
      end
      n_tests++;
      if (viol !== 0) begin
         n_fail++; $display("FAIL p1011_operand_stable: got %0d changes want 0", viol);
      end
      n_tests++;
      if (da !== 1'b0) begin
         n_fail++; $display("FAIL p1011_done_width: done still %b one cycle later, want 0", da);
      end
   endtask

   // elen=15 is clamped to 8: eight squares and one multiply give X^1.
   task automatic test_clamp;
      logic [7:0] res, exp_res;
      int cyc, pul, viol;
      logic da, ba, bb;
      exp_res = (CONV != 0) ? 8'h02 : 8'h05;
      run8(8'd5, 8'd9, 8'd13, 8'h01, 4'd15, 1'b0, 1'b0, res, cyc, pul, viol, da, ba, bb);
      n_tests++;
      if (res !== exp_res) begin
         n_fail++; $display("FAIL clamp_result: got %h want %h", res, exp_res);
      end
      n_tests++;
      if (pul !== 9 + CONV) begin
         n_fail++; $display("FAIL clamp_pulses: got %0d want %0d", pul, 9 + CONV);
      end
      n_tests++;
      if (cyc !== 64 + 6 * CONV) begin
         n_fail++; $display("FAIL clamp_cycles: got %0d want %0d", cyc, 64 + 6 * CONV);
      end
   endtask

   task automatic test_ignore;
      logic [7:0] res, exp_res;
      int cyc, pul, viol;
      logic da, ba, bb;
      exp_res = (CONV != 0) ? 8'h06 : 8'h02;
      run8(8'd5, 8'd9, 8'd13, 8'd5, 4'd3, 1'b1, 1'b1, res, cyc, pul, viol, da, ba, bb);
      n_tests++;
      if (res !== exp_res) begin
         n_fail++; $display("FAIL ignore_result: got %h want %h", res, exp_res);
      end
      n_tests++;
      if (cyc !== 35 + 6 * CONV || pul !== 5 + CONV) begin
         n_fail++; $display("FAIL ignore_timing: got %0d cycles %0d pulses want %0d %0d",
                            cyc, pul, 35 + 6 * CONV, 5 + CONV);
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] res, exp_res;
      int cyc, pul, viol, guard;
      logic da, ba, bb;
      exp_res = (CONV != 0) ? 8'h06 : 8'h02;
      @(negedge clk);
      x8 = 8'd5; r8 = 8'd9; m8 = 8'd13; e8 = 8'd5; elen8 = 4'd3; start8 = 1'b1;
      pul = 0; guard = 0;
      while (pul < 2 && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
         start8 = 1'b0;
         if (ms8) pul++;
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if (pul !== 2 || busy8 !== 1'b0 || done8 !== 1'b0 || ms8 !== 1'b0 ||
          ma8 !== 8'd0 || result8 !== 8'd0) begin
         n_fail++;
         $display("FAIL midreset: pulses=%0d busy=%b done=%b ms=%b a=%h result=%h, want 2 0 0 0 00 00",
                  pul, busy8, done8, ms8, ma8, result8);
      end
      @(negedge clk);
      reset = 1'b0;
      run8(8'd5, 8'd9, 8'd13, 8'd5, 4'd3, 1'b0, 1'b0, res, cyc, pul, viol, da, ba, bb);
      n_tests++;
      if (res !== exp_res || cyc !== 35 + 6 * CONV) begin
         n_fail++; $display("FAIL midreset_rerun: got %h in %0d cycles want %h in %0d",
                            res, cyc, exp_res, 35 + 6 * CONV);
      end
   endtask

   // m = 2^512-1, so R mod m = 1 and every Montgomery product is a plain product mod m.
   task automatic test_wide;
      logic [511:0] res, m, x;
      int cyc;
      m = '1;
      x = {16{32'hDEADBEEF}};
      run512(x, 512'd1, m, 512'd1, 10'd1, res, cyc);
      n_tests++;
      if (res !== x) begin
         n_fail++; $display("FAIL wide_e1_result: got %h want %h", res, x);
      end
      n_tests++;
      if (cyc !== 15 + 6 * CONV) begin
         n_fail++; $display("FAIL wide_e1_cycles: got %0d want %0d", cyc, 15 + 6 * CONV);
      end
      run512(512'd3, 512'd1, m, 512'd3, 10'd2, res, cyc);
      n_tests++;
      if (res !== 512'd27 || cyc !== 28 + 6 * CONV) begin
         n_fail++; $display("FAIL wide_e3_result: got %0d in %0d cycles want 27 in %0d",
                            res, cyc, 28 + 6 * CONV);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset = 1'b1;
      start8 = 1'b0; x8 = '0; r8 = '0; m8 = '0; e8 = '0; elen8 = '0; inj8 = 1'b0;
      start5 = 1'b0; x5 = '0; r5 = '0; m5 = '0; e5 = '0; elen5 = '0;
      test_reset();
      test_basic();
      test_elen_zero();
      test_pattern_1011();
      test_clamp();
      test_ignore();
      test_reset_mid();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
